uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial UART receiver, 8N1, LSB first, for the buffered `rx` line driven from the board top level. Runs in the divided system clock domain.
- Oversamples with a fixed clock-per-bit count and samples each bit at mid-bit.
- Delivers bytes through a valid/ready handshake and flags framing errors and overruns.
- The command parser in the core consumes its output.

Parameters:
- CLKS_PER_BIT, 579, clk cycles per UART bit (66.67 MHz / 115200). Legal range 4..65535.
- CNT_W, 16, width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; logic is in reset while reset==0.
- rx  input  1  asynchronous serial input; idle high.
- data  output  8  received byte; stable while valid==1.
- valid  output  1  byte available; held until accepted.
- ready  input  1  consumer accepts the byte when valid&&ready at a rising edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: a byte completed while the previous byte was still unaccepted; the new byte is dropped.
- busy  output  1  high in any state other than IDLE.

Behaviour:
Reset (reset==0, asynchronous):
- Synchronizer flops = 1.
- state = IDLE, counter = 0, bit index = 0, shift register = 0.
- data = 0x00, valid = 0, frame_err = 0, overrun = 0, busy = 0.

Synchronizer:
- rx passes through 2 flops (rxs). All decisions use rxs only.
- Deassertion of reset mid-frame restarts in IDLE. A partially received byte is never delivered.

FSM states and transitions:
- IDLE: when rxs==0, go to START with counter=0.
- START: counter increments each cycle. At counter==CLKS_PER_BIT/2-1 (integer division), sample rxs:
  - rxs==1: false start; return to IDLE with no output.
  - rxs==0: counter=0, bit index=0, go to DATA.
- DATA: at counter==CLKS_PER_BIT-1, sample rxs into shift bit [bit index] (LSB first) and set counter=0. After bit index 7, go to STOP.
- STOP: at counter==CLKS_PER_BIT-1, sample rxs:
  - rxs==1, valid==0 or ready==1 in that same cycle: next cycle data=shift, valid=1. Go to IDLE.
  - rxs==1, valid==1 and ready==0: next cycle overrun=1 for one cycle. data and valid are unchanged and the new byte is discarded. Go to IDLE.
  - rxs==0: next cycle frame_err=1 for one cycle, no valid. Go to BREAK.
- BREAK: wait for rxs==1, then go to IDLE. A held-low line therefore produces exactly one frame_err, not repeated frames.

Handshake:
- valid&&ready at a rising edge clears valid on the next cycle, unless a new byte loads in that same cycle; then valid stays 1 and data updates.
- data never changes while valid==1 && ready==0.

Timing and counters:
- Latency: valid rises 1 cycle after the stop-bit sample edge. That is CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after rxs first reads 0, plus 2 cycles of synchronizer delay from the pin.
- Counter never wraps: it is reset at every sample point, and the maximum value is CLKS_PER_BIT-1.
- Back-to-back frames: a start bit immediately following the stop sample is detected, because IDLE is entered half a bit before the stop bit ends.
- frame_err and overrun are never both asserted in the same cycle.

Test Plan:
(Bench uses CLKS_PER_BIT=16 and ready=1 unless stated.)
- Send 0xA5 with 16-cycle bits → single valid cycle with data=0xA5, at the computed latency (8+144+1+2 cycles from the pin falling edge). frame_err=0, overrun=0.
- Glitch: rx low for 4 cycles, then high → no valid, no frame_err. busy high briefly, then IDLE; a following 0x3C is received correctly.
- Send 0x3C with stop bit 0, then hold rx low for 50 cycles → exactly one frame_err pulse, no valid. Release rx and send 0x81 → data=0x81, valid.
- ready=0; send 0x11 then 0x22 → valid held with data=0x11. One overrun pulse at the end of the second frame, data still 0x11. Raise ready → valid drops the next cycle.
- Four back-to-back frames 0x00, 0xFF, 0x55, 0xAA with no idle gap → four valid pulses in order, no errors.
- Assert reset (0) mid-way through the data bits of 0x7E → all outputs return to their reset values immediately. After release, the remainder of the frame yields no valid and at most one frame_err; the next full frame 0x42 is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling with a fixed
// clocks-per-bit count, valid/ready byte output with frame error and overrun pulses.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 579,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rxs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    // An accepted byte drops valid unless a new byte loads in the same cycle.
    valid_d     = valid_q && !ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          if (rxs_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            cnt_d     = '0;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          shift_d[bit_idx_q] = rxs_q;
          cnt_d              = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = StIdle;
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            state_d     = StBreak;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StBreak: begin
        // Hold here until the line returns high so a stuck-low line flags only once.
        if (rxs_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus random frames, compared
// against an expected-byte / error-count model derived from the frame contents.
module tb_uart_rx_core;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Lat = 2 + Cpb / 2 + 9 * Cpb + 1;  // pin fall to first valid cycle

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_core #(
    .CLKS_PER_BIT(Cpb),
    .CNT_W       (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vhigh_cnt = 0;
  int         vrise_cyc = -1;
  int         last_fall = 0;
  logic       busy_seen = 1'b0;
  logic       valid_prev = 1'b0;
  logic       ready_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: record handshakes and pulses; check hold and exclusivity rules every cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (valid && ready) got_q.push_back(data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (busy) busy_seen = 1'b1;
      if (valid) vhigh_cnt++;
      if (valid && !valid_prev) vrise_cyc = cyc;
      if (valid_prev && !ready_prev) check("data_hold", data, data_prev);
      if (frame_err || overrun) check("err_exclusive", 32'(frame_err & overrun), 0);
      valid_prev = valid;
      ready_prev = ready;
      data_prev  = data;
    end else begin
      valid_prev = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    last_fall = cyc;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(Cpb);
    end
    rx = stop;
    tick(Cpb);
  endtask

  task automatic clear_counts();
    fe_cnt = 0;
    ov_cnt = 0;
    vhigh_cnt = 0;
    vrise_cyc = -1;
    busy_seen = 1'b0;
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, data, 8'h00);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int exp_fe;
    logic [7:0] b;
    logic stop;

    reset = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    idle(10);

    // Single byte, exact latency
    clear_counts();
    send_frame(8'hA5, 1'b1);
    idle(20);
    exp_q.push_back(8'hA5);
    check("a5_latency", vrise_cyc - last_fall, Lat);
    check("a5_vhigh", vhigh_cnt, 1);
    check("a5_fe", fe_cnt, 0);
    check("a5_ov", ov_cnt, 0);
    compare_bytes("a5");

    // Glitch shorter than half a bit
    clear_counts();
    rx = 1'b0;
    tick(4);
    idle(30);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy_after", busy, 1'b0);
    check("glitch_fe", fe_cnt, 0);
    compare_bytes("glitch");
    send_frame(8'h3C, 1'b1);
    idle(20);
    exp_q.push_back(8'h3C);
    compare_bytes("after_glitch");

    // Bad stop bit followed by a held-low line
    clear_counts();
    send_frame(8'h3C, 1'b0);
    tick(50);
    idle(20);
    check("break_fe", fe_cnt, 1);
    check("break_vhigh", vhigh_cnt, 0);
    compare_bytes("break");
    send_frame(8'h81, 1'b1);
    idle(20);
    exp_q.push_back(8'h81);
    compare_bytes("after_break");

    // Overrun with consumer stalled
    clear_counts();
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(5);
    send_frame(8'h22, 1'b1);
    idle(20);
    check("ovr_valid", valid, 1'b1);
    check("ovr_data", data, 8'h11);
    check("ovr_count", ov_cnt, 1);
    check("ovr_fe", fe_cnt, 0);
    check("ovr_none_taken", got_q.size(), 0);
    ready = 1'b1;
    tick(1);
    check("ovr_valid_drop", valid, 1'b0);
    exp_q.push_back(8'h11);
    compare_bytes("ovr");
    idle(10);

    // Back-to-back frames, no idle gap
    clear_counts();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle(20);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    check("b2b_fe", fe_cnt, 0);
    check("b2b_ov", ov_cnt, 0);
    check("b2b_vhigh", vhigh_cnt, 4);
    compare_bytes("b2b");

    // Random frames: bytes with a good stop bit are delivered, bad stop bits flag once
    clear_counts();
    exp_fe = 0;
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      send_frame(b, stop);
      if (stop) begin
        exp_q.push_back(b);
        idle($urandom_range(5));
      end else begin
        exp_fe++;
        idle(4 + $urandom_range(5));
      end
    end
    idle(20);
    check("rand_fe", fe_cnt, exp_fe);
    check("rand_ov", ov_cnt, 0);
    compare_bytes("rand");

    // Reset asserted mid-data, released during the stop bit
    clear_counts();
    fork
      send_frame(8'h7E, 1'b1);
      begin
        tick(Cpb + 4 * Cpb + Cpb / 2);
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick(Cpb * 4);
        reset = 1'b1;
      end
    join
    idle(20);
    check("mid_vhigh", vhigh_cnt, 0);
    check("mid_fe_le1", 32'(fe_cnt <= 1), 1);
    compare_bytes("mid");
    send_frame(8'h42, 1'b1);
    idle(20);
    exp_q.push_back(8'h42);
    compare_bytes("after_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
